// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART core.
package uart_pkg;

  typedef enum logic [1:0] {NONE, EVEN, ODD, RSVD} parity_mode_e;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int SAMPLE_TICK = 7;

  // Reserved mode behaves like no parity.
  function automatic logic parity_on(input parity_mode_e m);
    return (m == EVEN) || (m == ODD);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Oversample tick generator: one tick every baud_div+1 clocks, 16 ticks per bit.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BAUD_DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      restart,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
  output logic                      tick,
  output logic [3:0]                tick_idx,
  output logic                      bit_end
);

  logic [BAUD_DIV_WIDTH-1:0] div_cnt;

  assign tick    = (div_cnt == baud_div);
  assign bit_end = tick && (tick_idx == 4'(OVERSAMPLE - 1));

  // Divider and tick index; restart re-aligns bit timing to the frame start.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      div_cnt  <= '0;
      tick_idx <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_idx <= tick_idx + 4'd1;
    end else begin
      div_cnt  <= div_cnt + BAUD_DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_core_cfg.sv
// Runtime-configurable UART transceiver, 16x oversampling, full duplex.
// Optional break detection is compiled in with UART_RX_BREAK_DETECT_EN.
module uart_core_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_DIV_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]                parity_mode,
  input  logic                      stop_bits2,
  input  logic                      rx_uart,
  output logic                      tx_uart,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_valid,
  output logic                      rx_parity_err,
  output logic                      rx_frame_err,
  output logic                      rx_break
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // ---------------- TX ----------------
  tx_state_e                 tx_state, tx_state_nxt;
  logic [DATA_WIDTH-1:0]     tx_shreg;
  logic [CNT_W-1:0]          tx_bit_cnt;
  logic                      tx_stop_cnt, tx_stop2, tx_par, rdy_en;
  parity_mode_e              tx_mode;
  logic [BAUD_DIV_WIDTH-1:0] tx_div;
  logic                      tx_hs, tx_last_stop, tx_line;
  logic                      tx_tick, tx_bit_end;
  logic [3:0]                tx_tick_idx;
  logic                      tx_unused;

  assign tx_unused = ^{tx_tick, tx_tick_idx};

  uart_baud_cnt #(.BAUD_DIV_WIDTH(BAUD_DIV_WIDTH)) u_tx_baud (
    .clk(clk), .reset(reset), .restart(tx_hs), .baud_div(tx_div),
    .tick(tx_tick), .tick_idx(tx_tick_idx), .bit_end(tx_bit_end)
  );

  // TX next state, handshake and next line level. Ready also asserts in the
  // last clock of the final stop bit so a queued word follows with no gap.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_last_stop = (tx_state == TX_STOP) && tx_bit_end && (tx_stop_cnt == tx_stop2);
    tx_ready     = rdy_en && ((tx_state == TX_IDLE) || tx_last_stop);
    tx_hs        = tx_valid && tx_ready;
    case (tx_state)
      TX_IDLE:   if (tx_hs) tx_state_nxt = TX_START;
      TX_START:  if (tx_bit_end) tx_state_nxt = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_bit_cnt == LAST_BIT)
                   tx_state_nxt = parity_on(tx_mode) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_state_nxt = TX_STOP;
      TX_STOP:   if (tx_last_stop) tx_state_nxt = tx_hs ? TX_START : TX_IDLE;
      default:   tx_state_nxt = TX_IDLE;
    endcase
    case (tx_state_nxt)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = (tx_state == TX_DATA && tx_bit_end) ? tx_shreg[1] : tx_shreg[0];
      TX_PARITY: tx_line = tx_par;
      default:   tx_line = 1'b1;
    endcase
  end

  // TX state register, config latch at handshake, shifter and registered line.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_uart     <= 1'b1;
      rdy_en      <= 1'b0;
      tx_shreg    <= '0;
      tx_bit_cnt  <= '0;
      tx_stop_cnt <= 1'b0;
      tx_stop2    <= 1'b0;
      tx_mode     <= NONE;
      tx_div      <= '0;
      tx_par      <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      tx_state <= tx_state_nxt;
      tx_uart  <= tx_line;
      if (tx_hs) begin
        tx_shreg    <= tx_data;
        tx_bit_cnt  <= '0;
        tx_stop_cnt <= 1'b0;
        tx_stop2    <= stop_bits2;
        tx_mode     <= parity_mode_e'(parity_mode);
        tx_div      <= baud_div;
        tx_par      <= (^tx_data) ^ (parity_mode_e'(parity_mode) == ODD);
      end else if (tx_bit_end) begin
        if (tx_state == TX_DATA) begin
          tx_shreg   <= tx_shreg >> 1;
          tx_bit_cnt <= tx_bit_cnt + CNT_W'(1);
        end
        if (tx_state == TX_STOP) tx_stop_cnt <= 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_e                 rx_state, rx_state_nxt;
  logic [SYNC_STAGES-1:0]    rx_sync;
  logic                      rxs, rx_prev, rx_par, rx_start, rx_sample;
  logic [DATA_WIDTH-1:0]     rx_shreg;
  logic [CNT_W-1:0]          rx_bit_cnt;
  parity_mode_e              rx_mode;
  logic [BAUD_DIV_WIDTH-1:0] rx_div;
  logic                      rx_tick, rx_bit_end;
  logic [3:0]                rx_tick_idx;

  assign rxs       = rx_sync[SYNC_STAGES-1];
  assign rx_start  = (rx_state == RX_IDLE) && rx_prev && !rxs;
  assign rx_sample = rx_tick && (rx_tick_idx == 4'(SAMPLE_TICK));

  uart_baud_cnt #(.BAUD_DIV_WIDTH(BAUD_DIV_WIDTH)) u_rx_baud (
    .clk(clk), .reset(reset), .restart(rx_start), .baud_div(rx_div),
    .tick(rx_tick), .tick_idx(rx_tick_idx), .bit_end(rx_bit_end)
  );

  // Metastability guard on the asynchronous line; idles high through reset.
  always_ff @(posedge clk) begin
    if (reset) rx_sync <= '1;
    else       rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_uart};
  end

  // RX next state: glitch reject at mid start bit, leave at mid stop bit.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_start) rx_state_nxt = RX_START;
      RX_START:  if (rx_sample && rxs) rx_state_nxt = RX_IDLE;
                 else if (rx_bit_end) rx_state_nxt = RX_DATA;
      RX_DATA:   if (rx_bit_end && rx_bit_cnt == LAST_BIT)
                   rx_state_nxt = parity_on(rx_mode) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_bit_end) rx_state_nxt = RX_STOP;
      RX_STOP:   if (rx_sample) rx_state_nxt = RX_IDLE;
      default:   rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX state register, edge history, sampling and result registers.
  // Edge history tracks the line continuously, so after a break the next
  // start is only seen once the line has returned high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state      <= RX_IDLE;
      rx_prev       <= 1'b1;
      rx_par        <= 1'b0;
      rx_shreg      <= '0;
      rx_bit_cnt    <= '0;
      rx_mode       <= NONE;
      rx_div        <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_prev  <= rxs;
      rx_valid <= 1'b0;
      if (rx_start) begin
        rx_div     <= baud_div;
        rx_mode    <= parity_mode_e'(parity_mode);
        rx_bit_cnt <= '0;
      end
      if (rx_state == RX_DATA && rx_sample) rx_shreg <= {rxs, rx_shreg[DATA_WIDTH-1:1]};
      if (rx_state == RX_DATA && rx_bit_end) rx_bit_cnt <= rx_bit_cnt + CNT_W'(1);
      if (rx_state == RX_PARITY && rx_sample) rx_par <= rxs;
      if (rx_state == RX_STOP && rx_sample) begin
        rx_data       <= rx_shreg;
        rx_valid      <= 1'b1;
        rx_parity_err <= parity_on(rx_mode) && (rx_par != ((^rx_shreg) ^ (rx_mode == ODD)));
        rx_frame_err  <= !rxs;
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic rx_break_q;
  // Break: whole frame low, including parity when enabled and the stop bit.
  always_ff @(posedge clk) begin
    if (reset) rx_break_q <= 1'b0;
    else       rx_break_q <= (rx_state == RX_STOP) && rx_sample && !rxs &&
                             (rx_shreg == '0) && (!parity_on(rx_mode) || !rx_par);
  end
  assign rx_break = rx_break_q;
`else
  assign rx_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core_cfg.sv
// Self-checking bench for uart_core_cfg: directed steps with randomized frames.
module tb_uart_core_cfg;

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd1;
  logic [1:0]  parity_mode = 2'd0;
  logic        stop_bits2 = 1'b0;
  logic        rx_uart;
  logic        tx_uart;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_parity_err, rx_frame_err, rx_break;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;

  assign rx_uart = loop ? tx_uart : rx_drv;

  uart_core_cfg dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop_bits2(stop_bits2), .rx_uart(rx_uart), .tx_uart(tx_uart),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_break(rx_break)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; logic pe; logic fe; logic br; int c; } rx_rec_t;
  rx_rec_t rxq[$];

  always @(negedge clk)
    if (rx_valid) rxq.push_back('{rx_data, rx_parity_err, rx_frame_err, rx_break, cyc});

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: the frame as a list of line levels, one per bit time.
  bit fbits [0:15];
  function automatic int build_frame(input logic [7:0] w, input logic [1:0] m, input logic s2);
    int n;
    n = 0;
    fbits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin fbits[n] = w[i]; n++; end
    if (m == 2'd1 || m == 2'd2) begin fbits[n] = exp_par(w, m); n++; end
    fbits[n] = 1'b1; n++;
    if (s2) begin fbits[n] = 1'b1; n++; end
    return n;
  endfunction

  function automatic logic exp_par(input logic [7:0] w, input logic [1:0] m);
    return (($countones(w) % 2) == 1) ^ (m == 2'd2);
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!tx_ready && k < 5000) begin step(1); k++; end
    chk(tag, tx_ready, 1);
  endtask

  // One TX frame, checking first and last clock of every bit; config is
  // scrambled right after the handshake to show it was latched.
  task automatic tx_frame_check(input logic [7:0] w, input logic [1:0] m, input logic s2, input int bd);
    int n, t;
    parity_mode = m; stop_bits2 = s2; baud_div = 16'(bd); tx_data = w; tx_valid = 1'b1;
    wait_ready("tx_ready_pre");
    step(1);
    tx_valid = 1'b0;
    parity_mode = 2'($urandom); stop_bits2 = 1'($urandom); baud_div = 16'($urandom_range(0, 3));
    n = build_frame(w, m, s2);
    t = 16 * (bd + 1);
    for (int c = 0; c < n * t; c++) begin
      if (c % t == 0)     chk($sformatf("tx_bit%0d_first", c / t), tx_uart, fbits[c / t]);
      if (c % t == t - 1) chk($sformatf("tx_bit%0d_last", c / t), tx_uart, fbits[c / t]);
      if (c == n * t - 2) chk("tx_ready_busy", tx_ready, 0);
      step(1);
    end
    chk("tx_ready_done", tx_ready, 1);
    chk("tx_idle_line", tx_uart, 1);
  endtask

  task automatic rx_send(input logic [7:0] w, input logic [1:0] m, input logic pb, input logic sb,
                         input int bd, input int low_tail);
    int t;
    t = 16 * (bd + 1);
    parity_mode = m; baud_div = 16'(bd);
    rx_drv = 1'b0; step(t);
    for (int i = 0; i < 8; i++) begin rx_drv = w[i]; step(t); end
    if (m == 2'd1 || m == 2'd2) begin rx_drv = pb; step(t); end
    rx_drv = sb; step(t);
    if (low_tail > 0) begin rx_drv = 1'b0; step(low_tail); end
    rx_drv = 1'b1; step(t);
  endtask

  task automatic rx_expect(input string tag, input logic [7:0] w, input logic pe, input logic fe, input logic br);
    rx_rec_t r;
    chk({tag, "_cnt"}, rxq.size(), 1);
    if (rxq.size() > 0) begin
      r = rxq.pop_front();
      chk({tag, "_data"}, r.d, w);
      chk({tag, "_perr"}, r.pe, pe);
      chk({tag, "_ferr"}, r.fe, fe);
      chk({tag, "_brk"}, r.br, br);
    end
    rxq.delete();
  endtask

  task automatic rx_random(input string tag, input logic [7:0] w, input logic [1:0] m, input logic pb,
                           input logic sb, input int bd);
    logic pon, pe, br;
    pon = (m == 2'd1 || m == 2'd2);
    pe  = pon && (pb != exp_par(w, m));
    br  = BRK_EN && (w == 8'h00) && (!pon || !pb) && !sb;
    rx_send(w, m, pb, sb, bd, 0);
    rx_expect(tag, w, pe, !sb, br);
  endtask

  // Loopback of the words in lbw, sent back-to-back.
  logic [7:0] lbw[$];
  task automatic loop_run(input logic [1:0] m, input logic s2, input int bd);
    int t, nb;
    t  = 16 * (bd + 1);
    nb = 10 + ((m == 2'd1 || m == 2'd2) ? 1 : 0) + (s2 ? 1 : 0);
    loop = 1'b1; parity_mode = m; stop_bits2 = s2; baud_div = 16'(bd);
    rxq.delete();
    step(2);
    foreach (lbw[i]) begin
      tx_data = lbw[i]; tx_valid = 1'b1;
      wait_ready("lb_ready");
      step(1);
    end
    tx_valid = 1'b0;
    step(nb * t + 40);
    chk("lb_cnt", rxq.size(), lbw.size());
    foreach (lbw[i]) begin
      if (i < rxq.size()) begin
        chk($sformatf("lb%0d_data", i), rxq[i].d, lbw[i]);
        chk($sformatf("lb%0d_perr", i), rxq[i].pe, 0);
        chk($sformatf("lb%0d_ferr", i), rxq[i].fe, 0);
        if (i > 0) chk($sformatf("lb%0d_space", i), rxq[i].c - rxq[i-1].c, nb * t);
      end
    end
    rxq.delete();
    loop = 1'b0;
    step(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] m;
    // Reset values
    step(3);
    chk("rst_tx_uart", tx_uart, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_perr", rx_parity_err, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_brk", rx_break, 0);
    reset = 1'b0;
    step(1);
    chk("post_rst_ready", tx_ready, 1);

    // TX: 0xA5, even parity, one stop, baud_div=1 (352 clocks total)
    tx_frame_check(8'hA5, 2'd1, 1'b0, 1);
    for (int i = 0; i < 5; i++)
      tx_frame_check(8'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 2));

    // Loopback: odd parity, two stops, back-to-back 0x00, 0xFF, 0x3C
    lbw = '{8'h00, 8'hFF, 8'h3C};
    loop_run(2'd2, 1'b1, 1);
    lbw = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    loop_run(2'($urandom), 1'($urandom), $urandom_range(0, 2));

    // RX parity error: 0xA5 even parity with parity bit 1
    rx_send(8'hA5, 2'd1, 1'b1, 1'b1, 1, 0);
    rx_expect("rx_perr", 8'hA5, 1'b1, 1'b0, 1'b0);

    // RX framing error with a random word
    rx_random("rx_ferr", 8'($urandom), 2'd0, 1'b0, 1'b0, 1);

    // All-zero frame with the line held low afterwards: one frame only
    rx_send(8'h00, 2'd0, 1'b0, 1'b0, 1, 64);
    rx_expect("rx_break", 8'h00, 1'b0, 1'b1, BRK_EN);

    // Short glitch is rejected, following frame is received
    baud_div = 16'd1;
    rx_drv = 1'b0; step(8);
    rx_drv = 1'b1; step(96);
    chk("glitch_no_valid", rxq.size(), 0);
    rx_random("post_glitch", 8'h5A, 2'd2, exp_par(8'h5A, 2'd2), 1'b1, 1);

    // Randomized RX frames
    for (int i = 0; i < 6; i++) begin
      m = 2'($urandom);
      rx_random($sformatf("rx_rand%0d", i), 8'($urandom), m, 1'($urandom),
                ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
    end

    // Reset in the middle of a TX frame and an RX frame
    parity_mode = 2'd0; stop_bits2 = 1'b0; baud_div = 16'd1;
    tx_data = 8'($urandom); tx_valid = 1'b1;
    wait_ready("mid_rst_ready");
    step(1);
    tx_valid = 1'b0;
    rx_drv = 1'b0; step(32);
    rx_drv = 1'b1; step(32);
    rx_drv = 1'b0; step(40);
    reset = 1'b1; rx_drv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("mid_rst_tx_uart", tx_uart, 1);
      chk("mid_rst_tx_ready", tx_ready, 0);
      chk("mid_rst_rx_valid", rx_valid, 0);
    end
    reset = 1'b0;
    step(1);
    chk("mid_rst_ready_after", tx_ready, 1);
    step(400);
    chk("mid_rst_no_rx", rxq.size(), 0);
    chk("mid_rst_line_idle", tx_uart, 1);
    tx_frame_check(8'($urandom), 2'($urandom), 1'($urandom), 1);
    rx_random("post_rst_rx", 8'($urandom), 2'd1, 1'($urandom), 1'b1, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
